// File: rtl/disp_scan_ctrl_if.sv
// Signal bundle between the display scan controller and the board:
// mode button and selector nibbles in, view select and LED drive out.
interface disp_scan_ctrl_if;
   logic       btn_mode;
   logic [3:0] result1;
   logic [3:0] result2;
   logic [3:0] result3;
   logic [3:0] result4;
   logic [1:0] disp;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output btn_mode, result1, result2, result3, result4,
      input  disp, an, seg, dp
   );

   modport slave (
      input  btn_mode, result1, result2, result3, result4,
      output disp, an, seg, dp
   );
endinterface

// File: rtl/disp_scan_ctrl.sv
// 4-digit 7-segment scan controller: owns the INST/INDEX/ACC view mode,
// debounces the mode button, multiplexes and hex-decodes the four nibbles.
module disp_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEB_CNT      = 1000000,
   parameter int BLANK_CYCLES = 200000
) (
   input  logic             clk,
   input  logic             rst,
   disp_scan_ctrl_if.slave  bus
);

   localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W   = $clog2(DEB_CNT + 1);
   localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_INST  = 2'd0,
      ST_INDEX = 2'd1,
      ST_ACC   = 2'd2
   } mode_t;

   logic               r_btn_p0;
   logic               r_btn_p1;
   logic               r_deb;
   logic               r_deb_q;
   logic [DEB_W-1:0]   r_deb_cnt;
   mode_t              r_mode;
   logic [1:0]         r_disp;
   logic [BLANK_W-1:0] r_blank;
   logic [SCAN_W-1:0]  r_pre;
   logic [1:0]         r_idx;
   logic [3:0]         r_an;
   logic [6:0]         r_seg;
   logic               r_dp;

   logic               w_adv;
   logic [3:0]         w_nib;
   logic [1:0]         w_mode_num;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Button: two-flop synchronizer, then debounce counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_p0  <= 1'b0;
         r_btn_p1  <= 1'b0;
         r_deb     <= 1'b0;
         r_deb_q   <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_btn_p0 <= bus.btn_mode;
         r_btn_p1 <= r_btn_p0;
         r_deb_q  <= r_deb;
         if (r_btn_p1 != r_deb) begin
            if (r_deb_cnt == DEB_W'(DEB_CNT - 1)) begin
               r_deb     <= r_btn_p1;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + 1'b1;
            end
         end else begin
            r_deb_cnt <= '0;
         end
      end
   end

   // Rising edge of the debounced level only; release is ignored
   assign w_adv = r_deb & ~r_deb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= ST_INST;
         r_disp <= 2'b00;
      end else if (w_adv) begin
         case (r_mode)
            ST_INST: begin
               r_mode <= ST_INDEX;
               r_disp <= 2'b10;
            end
            ST_INDEX: begin
               r_mode <= ST_ACC;
               r_disp <= 2'b11;
            end
            default: begin
               r_mode <= ST_INST;
               r_disp <= 2'b00;
            end
         endcase
      end
   end

   // Blank timer and free-running digit scan
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blank <= '0;
         r_pre   <= '0;
         r_idx   <= 2'd0;
      end else begin
         if (w_adv)
            r_blank <= BLANK_W'(BLANK_CYCLES);
         else if (r_blank != '0)
            r_blank <= r_blank - 1'b1;

         if (r_pre == SCAN_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

   always_comb begin
      w_nib = bus.result1;
      case (r_idx)
         2'd0: w_nib = bus.result1;
         2'd1: w_nib = bus.result2;
         2'd2: w_nib = bus.result3;
         default: w_nib = bus.result4;
      endcase
   end

   assign w_mode_num = r_mode;

   // Registered LED drive, one cycle behind index and nibble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an  <= 4'b1111;
         r_seg <= 7'b1111111;
         r_dp  <= 1'b1;
      end else begin
         r_seg <= hex_to_seg(w_nib);
         if (r_blank != '0) begin
            r_an <= 4'b1111;
            r_dp <= 1'b1;
         end else begin
            r_an <= ~(4'b0001 << r_idx);
            r_dp <= (r_idx == w_mode_num) ? 1'b0 : 1'b1;
         end
      end
   end

   assign bus.disp = r_disp;
   assign bus.an   = r_an;
   assign bus.seg  = r_seg;
   assign bus.dp   = r_dp;

endmodule
